// File: rtl/qu_pkg.sv
// Shared types for the Qu Tomasulo core.
// Tag value zero marks a register with no pending writer.
package qu_pkg;

  localparam int QI_W = 6;
  localparam int RF_W = 32;
  localparam int RD_W = 5;

  localparam logic [QI_W-1:0] QI_NONE = '0;

  typedef logic [QI_W-1:0] tag_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic [RD_W-1:0] rd;
    logic [RF_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_wcnt.sv
// Per-register count of in-flight ROB writers.
// Same-cycle inc and dec on one register cancel out.
module rob_wcnt #(
  parameter int NREG = 32,
  parameter int CW   = 6
) (
  input  logic                    clk_i,
  input  logic                    clr_i,
  input  logic                    inc_en_i,
  input  logic [$clog2(NREG)-1:0] inc_idx_i,
  input  logic                    dec_en_i,
  input  logic [$clog2(NREG)-1:0] dec_idx_i,
  input  logic [$clog2(NREG)-1:0] rd_idx_i,
  output logic [CW-1:0]           rd_cnt_o
);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en_i)
      cnt_d[inc_idx_i] = cnt_d[inc_idx_i] + CW'(1);
    if (dec_en_i)
      cnt_d[dec_idx_i] = cnt_d[dec_idx_i] - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < NREG; i++)
        cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates rename tags, captures CDB
// results, retires in program order into the RF.
module rob
  import qu_pkg::*;
#(
  parameter int ROB_DEPTH = 32,
  parameter int RF_WIDTH  = 32,
  parameter int RF_DEPTH  = 32,
  parameter int QI_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [$clog2(RF_DEPTH)-1:0] alloc_rd,
  output logic [QI_WIDTH-1:0]         alloc_tag,
  input  logic                        cdb_valid,
  input  logic [QI_WIDTH-1:0]         cdb_tag,
  input  logic [RF_WIDTH-1:0]         cdb_data,
  input  logic [QI_WIDTH-1:0]         lk1_tag,
  input  logic [QI_WIDTH-1:0]         lk2_tag,
  output logic                        lk1_ready,
  output logic                        lk2_ready,
  output logic [RF_WIDTH-1:0]         lk1_data,
  output logic [RF_WIDTH-1:0]         lk2_data,
  output logic                        commit_valid,
  output logic [$clog2(RF_DEPTH)-1:0] commit_rd,
  output logic [RF_WIDTH-1:0]         commit_data,
  output logic [QI_WIDTH-1:0]         commit_tag,
  output logic                        commit_last_writer,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(ROB_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RF_DEPTH);
  localparam logic [QI_WIDTH-1:0] NONE = QI_WIDTH'(QI_NONE);

  logic [ROB_DEPTH-1:0] busy_q, done_q;
  logic [RW-1:0]        rd_q   [ROB_DEPTH];
  logic [RF_WIDTH-1:0]  data_q [ROB_DEPTH];
  logic [AW-1:0]        head_q, tail_q;
  logic [CW-1:0]        count_q, count_d;

  function automatic logic [AW-1:0] t2i(
    input logic [QI_WIDTH-1:0] t
  );
    return AW'(t - QI_WIDTH'(1));
  endfunction

  // Tags above ROB_DEPTH name no entry.
  function automatic logic tag_ok(
    input logic [QI_WIDTH-1:0] t
  );
    return (t != NONE) && (32'(t) <= 32'(ROB_DEPTH));
  endfunction

  logic          alloc_fire, conflict;
  logic          cdb_hit;
  logic [AW-1:0] cdb_idx, lk1_idx, lk2_idx;
  logic          lk1_byp, lk2_byp;
  logic [RW-1:0] rd_h;
  logic [CW-1:0] wcnt_h;

  assign full        = (count_q == CW'(ROB_DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = QI_WIDTH'(tail_q) + QI_WIDTH'(1);

  assign cdb_idx = t2i(cdb_tag);
  assign cdb_hit = cdb_valid && tag_ok(cdb_tag)
                && busy_q[cdb_idx];

  assign lk1_idx   = t2i(lk1_tag);
  assign lk1_byp   = cdb_valid && (cdb_tag == lk1_tag);
  assign lk1_ready = tag_ok(lk1_tag) && busy_q[lk1_idx]
                  && (done_q[lk1_idx] || lk1_byp);
  assign lk1_data  = lk1_byp ? cdb_data : data_q[lk1_idx];

  assign lk2_idx   = t2i(lk2_tag);
  assign lk2_byp   = cdb_valid && (cdb_tag == lk2_tag);
  assign lk2_ready = tag_ok(lk2_tag) && busy_q[lk2_idx]
                  && (done_q[lk2_idx] || lk2_byp);
  assign lk2_data  = lk2_byp ? cdb_data : data_q[lk2_idx];

  // RF data write beats qi write, so a same-rd alloc
  // would lose its tag; hold the commit a cycle.
  assign rd_h     = rd_q[head_q];
  assign conflict = alloc_fire && (alloc_rd == rd_h)
                 && (rd_h != '0);
  assign commit_valid = busy_q[head_q] && done_q[head_q]
                     && !flush && !conflict;
  assign commit_rd    = rd_h;
  assign commit_data  = data_q[head_q];
  assign commit_tag   = QI_WIDTH'(head_q) + QI_WIDTH'(1);
  assign commit_last_writer = (wcnt_h == CW'(1));

  always_comb begin
    count_d = count_q;
    unique case ({alloc_fire, commit_valid})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cdb_hit)
        done_q[cdb_idx] <= 1'b1;
      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + AW'(1);
      end
      if (commit_valid) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cdb_hit)
      data_q[cdb_idx] <= cdb_data;
    if (!rst && alloc_fire)
      rd_q[tail_q] <= alloc_rd;
  end

  rob_wcnt #(
    .NREG (RF_DEPTH),
    .CW   (CW)
  ) u_wcnt (
    .clk_i     (clk),
    .clr_i     (rst || flush),
    .inc_en_i  (alloc_fire),
    .inc_idx_i (alloc_rd),
    .dec_en_i  (commit_valid),
    .dec_idx_i (rd_h),
    .rd_idx_i  (rd_h),
    .rd_cnt_o  (wcnt_h)
  );

endmodule
